row_col_dec_5x5: RTL
====================

ROW_COL_DEC_5X5 -- requirements
Module: row_col_dec_5x5

Interface
REQ-001 SHALL have parameter SIZE, default 5: rows = cols of capacitor array.
REQ-002 SHALL have parameter MAX, default 25: largest decodable word.
REQ-003 SHALL have port clk, input, 1: sampling clock, posedge active.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1: sample-enable for the code inputs.
REQ-006 SHALL have port r_all, input, 5: full-row control, active-low thermometer.
REQ-007 SHALL have port row, input, 5: one-hot partial-row select.
REQ-008 SHALL have port col, input, 5: column thermometer of the partial row.
REQ-009 SHALL have port err_clr, input, 1: synchronous clear of err_cnt.
REQ-010 SHALL have port word, output, 5: last legally decoded word.
REQ-011 SHALL have port word_vld, output, 1: one-cycle pulse, word updated from a legal code.
REQ-012 SHALL have port word_chg, output, 1: one-cycle pulse, new legal word differs from previous word.
REQ-013 SHALL have port code_err, output, 1: one-cycle pulse, sampled code illegal.
REQ-014 SHALL have port err_cnt, output, 8: saturating count of illegal codes.

Function
REQ-015 SHALL register r_all/row/col into stage 1 at posedge when en=1; stage-1 valid flag SHALL equal en at that edge.
REQ-016 SHALL decode stage 1 and update outputs at the following posedge; inputs sampled at edge N appear at outputs after edge N+1 (latency 2 edges).
REQ-017 SHALL derive k = number of trailing zeros of r_all; legal r_all is 1..10..0 form with k in 0..4; r_all=00000 or non-thermometer is illegal.
REQ-018 SHALL require row == one-hot bit k; otherwise illegal.
REQ-019 SHALL, for k even, require col = LSB-first thermometer with c ones (bits i<c set), c in 0..5.
REQ-020 SHALL, for k odd, require col = MSB-first thermometer with c ones (bits i>=5-c set), c in 0..5.
REQ-021 SHALL compute word = 5*k + c in 5-bit unsigned arithmetic; result never exceeds MAX for legal codes.
REQ-022 SHALL treat k>0 with c=0 as legal (word = 5k); codes are not required to be canonical.
REQ-023 SHALL, on legal code: load word, pulse word_vld, pulse word_chg iff new word != held word.
REQ-024 SHALL, on illegal code: hold word, word_vld=0, word_chg=0, pulse code_err, increment err_cnt.
REQ-025 SHALL saturate err_cnt at 255.
REQ-026 SHALL, when err_clr=1 coincides with an error, result in err_cnt=1 (clear then count); otherwise err_clr gives 0.
REQ-027 SHALL, when stage-1 valid=0, leave word/err_cnt unchanged and drive all pulses 0.

Reset
REQ-028 SHALL on rst=1 immediately set word=0, word_vld=0, word_chg=0, code_err=0, err_cnt=0, stage-1 registers and valid=0.
REQ-029 SHALL discard any in-flight stage-1 sample on reset mid-operation; first output after release requires two en edges.

Structure
REQ-030 SHALL place SIZE, MAX, WORD_W=5, CNT_W=8 in shared package dco_pkg.
REQ-031 SHALL implement decode/legality as combinational sub-module row_col_dec_core (outputs k, c, legal).

Verification
REQ-032 Reset asserted -> word=0, word_vld=0, code_err=0, err_cnt=0 asynchronously.
REQ-033 en=1, r_all=11100, row=00100, col=00111 -> after 2nd edge word=13, word_vld=1, word_chg=1.
REQ-034 r_all=11110,row=00010,col=11000 -> word=7; then r_all=10000,row=10000,col=11111 -> word=25; repeat same code -> word_vld=1, word_chg=0.
REQ-035 row=00011 (any r_all) -> code_err=1 one cycle, word held, err_cnt+1; 300 consecutive illegal codes -> err_cnt=255; err_clr with error -> 1.
REQ-036 en=0 for 10 cycles with changing inputs -> no pulses, outputs hold; rst pulse between sample and output -> sample dropped.
REQ-037 Sweep all words 0..25 through encoder model (even-k LSB-first, odd-k MSB-first col) -> decoded word equals stimulus, zero errors.

Source files
------------

// File: rtl/dco_pkg.sv
// rtl/dco_pkg.sv - shared constants, sample type and mask helpers for the row/column decoder
package dco_pkg;

    localparam int SIZE   = 5;
    localparam int MAX    = 25;
    localparam int WORD_W = 5;
    localparam int CNT_W  = 8;
    localparam int IDX_W  = 3;

    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // One captured code as it sits in the first pipeline stage
    typedef struct packed {
        logic [SIZE-1:0] r_all;
        logic [SIZE-1:0] row;
        logic [SIZE-1:0] col;
    } code_t;

    // Bits i < n set (LSB-first thermometer with n ones)
    function automatic logic [SIZE-1:0] therm_lo(input int n);
        logic [SIZE-1:0] m;
        m = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Bits i >= n set (MSB-first thermometer with SIZE-n ones)
    function automatic logic [SIZE-1:0] therm_hi(input int n);
        logic [SIZE-1:0] m;
        m = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (i >= n) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Single bit n set; zero when n is out of range
    function automatic logic [SIZE-1:0] onehot(input int n);
        logic [SIZE-1:0] m;
        m = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (i == n) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Population count
    function automatic int ones(input logic [SIZE-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < SIZE; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/row_col_dec_core.sv
// rtl/row_col_dec_core.sv - combinational row/column code decode and legality check
module row_col_dec_core
    import dco_pkg::*;
(
    input  logic [SIZE-1:0]  r_all,
    input  logic [SIZE-1:0]  row,
    input  logic [SIZE-1:0]  col,
    output logic [IDX_W-1:0] k,
    output logic [IDX_W-1:0] c,
    output logic             legal
);

    int   tz;
    int   nc;
    logic r_ok;
    logic row_ok;
    logic col_ok;

    // Count trailing zeros of r_all (SIZE when all zero) and ones in col
    always_comb begin
        tz = SIZE;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (r_all[i]) tz = i;
        end
        nc = ones(col);
    end

    // r_all must be a clean 1..10..0 thermometer, row must mark the partial row,
    // and col must fill from the side that alternates with row parity (serpentine order)
    always_comb begin
        r_ok   = (tz < SIZE) && (r_all == therm_hi(tz));
        row_ok = (tz < SIZE) && (row == onehot(tz));
        if (tz[0]) begin
            col_ok = (col == therm_hi(SIZE - nc));
        end else begin
            col_ok = (col == therm_lo(nc));
        end
        legal = r_ok && row_ok && col_ok;
        k     = IDX_W'(tz);
        c     = IDX_W'(nc);
    end

endmodule

// File: rtl/row_col_dec_5x5.sv
// rtl/row_col_dec_5x5.sv - two-stage row/column thermometer decoder with error counting
module row_col_dec_5x5 #(
    parameter int SIZE = dco_pkg::SIZE,
    parameter int MAX  = dco_pkg::MAX
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [SIZE-1:0]           r_all,
    input  logic [SIZE-1:0]           row,
    input  logic [SIZE-1:0]           col,
    input  logic                      err_clr,
    output logic [dco_pkg::WORD_W-1:0] word,
    output logic                      word_vld,
    output logic                      word_chg,
    output logic                      code_err,
    output logic [dco_pkg::CNT_W-1:0] err_cnt
);

    import dco_pkg::*;

    code_t             s1;
    logic              s1_vld;
    logic [IDX_W-1:0]  dec_k;
    logic [IDX_W-1:0]  dec_c;
    logic              dec_legal;
    int                w_int;
    logic              code_ok;
    logic [WORD_W-1:0] next_word;

    // Stage 1: capture the code when enabled; valid tracks en every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= en;
            if (en) begin
                s1.r_all <= r_all;
                s1.row   <= row;
                s1.col   <= col;
            end
        end
    end

    row_col_dec_core u_core (
        .r_all (s1.r_all),
        .row   (s1.row),
        .col   (s1.col),
        .k     (dec_k),
        .c     (dec_c),
        .legal (dec_legal)
    );

    // Word value of the staged code; the MAX bound is a backstop on the decode
    always_comb begin
        w_int     = SIZE * int'(dec_k) + int'(dec_c);
        code_ok   = dec_legal && (w_int <= MAX);
        next_word = WORD_W'(w_int);
    end

    // Stage 2: update word and pulses, count illegal codes with saturation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= '0;
            word_vld <= 1'b0;
            word_chg <= 1'b0;
            code_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            word_vld <= 1'b0;
            word_chg <= 1'b0;
            code_err <= 1'b0;
            if (s1_vld && code_ok) begin
                word     <= next_word;
                word_vld <= 1'b1;
                word_chg <= (next_word != word);
            end
            if (s1_vld && !code_ok) begin
                code_err <= 1'b1;
                if (err_clr) begin
                    err_cnt <= CNT_ONE;
                end else if (err_cnt != CNT_SAT) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end else if (err_clr) begin
                err_cnt <= '0;
            end
        end
    end

endmodule
